// File: rtl/frame_tx_100m.sv
// Serial frame transmitter: one 56-bit {SYNC, CNT, DATA, CRC-8} frame per accepted word,
// MSB first, one bit per bit_valid strobe every BIT_DIV clocks, with a one-word holding register.
module frame_tx_100m #(
   parameter int unsigned BIT_DIV  = 4,
   parameter logic [7:0]  SYNC_PAT = 8'hAA
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        tx_en,
   input  logic [31:0] data_in,
   input  logic        data_in_valid,
   output logic        data_in_ready,
   output logic        bit_out,
   output logic        bit_valid,
   output logic        frame_start,
   output logic        busy
);

   localparam int unsigned   DW      = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(BIT_DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state;
   logic [31:0]   hold_reg;
   logic          hold_full;
   logic [55:0]   shift_reg;
   logic [DW-1:0] div_cnt;
   logic [5:0]    bit_idx;
   logic [7:0]    cnt;
   logic          accept;
   logic          strobe;
   logic          last_bit;
   logic          load;
   logic [7:0]    crc;

   // CRC-8, poly 0x07, init 0, MSB first, no reflection or final XOR
   function automatic logic [7:0] crc8(input logic [47:0] d);
      logic [7:0] c;
      logic       fb;
      c = '0;
      for (int unsigned i = 0; i < 48; i++) begin
         fb = c[7] ^ d[47 - i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   assign data_in_ready = ~hold_full;
   assign busy          = (state == SHIFT);

   always_comb begin
      accept   = data_in_valid & ~hold_full;
      strobe   = (state == SHIFT) && (div_cnt == DIV_MAX);
      last_bit = strobe && (bit_idx == 6'd55);
      load     = tx_en & hold_full & ((state == IDLE) | last_bit);
      crc      = crc8({SYNC_PAT, cnt, hold_reg});
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold_reg    <= '0;
         hold_full   <= 1'b0;
         shift_reg   <= '0;
         div_cnt     <= '0;
         bit_idx     <= '0;
         cnt         <= '0;
         bit_out     <= 1'b0;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         if (load)
            hold_full <= 1'b0;
         if (accept) begin
            hold_reg  <= data_in;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               bit_valid   <= 1'b0;
               frame_start <= 1'b0;
            end
            SHIFT: begin
               if (strobe) begin
                  bit_out     <= shift_reg[55];
                  bit_valid   <= 1'b1;
                  frame_start <= (bit_idx == '0);
                  shift_reg   <= shift_reg << 1;
                  div_cnt     <= '0;
                  if (last_bit) begin
                     bit_idx <= '0;
                     state   <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + 6'd1;
                  end
               end else begin
                  div_cnt     <= div_cnt + DW'(1);
                  bit_valid   <= 1'b0;
                  frame_start <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase

         // A load on the last-bit strobe overrides the shift/IDLE updates above, giving a zero-gap frame
         if (load) begin
            shift_reg <= {SYNC_PAT, cnt, hold_reg, crc};
            cnt       <= cnt + 8'd1;
            div_cnt   <= '0;
            bit_idx   <= '0;
            state     <= SHIFT;
         end
      end
   end

endmodule

// File: tb/tb_frame_tx_100m.sv
// Directed self-checking bench for frame_tx_100m: a BIT_DIV=4 instance and a BIT_DIV=1 instance,
// with frames reassembled from the serial output and compared against a polynomial-division CRC model.
module tb_frame_tx_100m;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, tx_en_a, vld_a, rdy_a, bo_a, bv_a, fs_a, busy_a;
   logic [31:0] din_a;
   logic        rst_b, tx_en_b, vld_b, rdy_b, bo_b, bv_b, fs_b, busy_b;
   logic [31:0] din_b;

   frame_tx_100m #(.BIT_DIV(4), .SYNC_PAT(8'hAA)) dut_a (
      .clk_sys(clk), .rst_n(rst_a), .tx_en(tx_en_a), .data_in(din_a), .data_in_valid(vld_a),
      .data_in_ready(rdy_a), .bit_out(bo_a), .bit_valid(bv_a), .frame_start(fs_a), .busy(busy_a));

   frame_tx_100m #(.BIT_DIV(1), .SYNC_PAT(8'hAA)) dut_b (
      .clk_sys(clk), .rst_n(rst_b), .tx_en(tx_en_b), .data_in(din_b), .data_in_valid(vld_b),
      .data_in_ready(rdy_b), .bit_out(bo_b), .bit_valid(bv_b), .frame_start(fs_b), .busy(busy_b));

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // CRC as the remainder of {sync,cnt,data,8'h00} divided by 0x107
   function automatic logic [55:0] frame_of(input logic [7:0] c, input logic [31:0] d);
      logic [55:0] r;
      r = {8'hAA, c, d, 8'h00};
      for (int i = 55; i >= 8; i--)
         if (r[i]) r = r ^ (56'h107 << (i - 8));
      return {8'hAA, c, d, r[7:0]};
   endfunction

   logic [55:0] acc_a, acc_b;
   logic [55:0] frames_a[$], frames_b[$];
   int          first_a[$], first_b[$], last_a[$];
   int          nbits_a = 0, nbits_b = 0, prev_a = -1, prev_b = -1;
   int          gap_bad_a = 0, gap_bad_b = 0, fs_bad_a = 0, fs_bad_b = 0;
   bit          gap_chk_a = 1'b0, gap_chk_b = 1'b0;
   logic        busy_last_b;

   always @(posedge clk) begin
      #1;
      if (!rst_a) nbits_a = 0;
      else if (bv_a) begin
         if (fs_a !== (nbits_a == 0)) fs_bad_a++;
         if (nbits_a == 0) first_a.push_back(cyc);
         if (gap_chk_a && prev_a >= 0 && cyc - prev_a != 4) gap_bad_a++;
         prev_a = cyc;
         acc_a  = {acc_a[54:0], bo_a};
         nbits_a++;
         if (nbits_a == 56) begin
            frames_a.push_back(acc_a);
            last_a.push_back(cyc);
            nbits_a = 0;
         end
      end
      if (!rst_b) nbits_b = 0;
      else if (bv_b) begin
         if (fs_b !== (nbits_b == 0)) fs_bad_b++;
         if (nbits_b == 0) first_b.push_back(cyc);
         if (gap_chk_b && prev_b >= 0 && cyc - prev_b != 1) gap_bad_b++;
         prev_b = cyc;
         acc_b  = {acc_b[54:0], bo_b};
         nbits_b++;
         if (nbits_b == 56) begin
            frames_b.push_back(acc_b);
            busy_last_b = busy_b;
            nbits_b = 0;
         end
      end
   end

   task automatic send_a(input logic [31:0] w, output int t);
      int n = 0;
      @(negedge clk);
      din_a = w;
      vld_a = 1'b1;
      while (!rdy_a && n < 20000) begin @(negedge clk); n++; end
      if (n >= 20000) check("send_a_ready", rdy_a, 1);
      @(posedge clk);
      #1;
      t     = cyc;
      vld_a = 1'b0;
   endtask

   task automatic send_b(input logic [31:0] w, output int t);
      int n = 0;
      @(negedge clk);
      din_b = w;
      vld_b = 1'b1;
      while (!rdy_b && n < 20000) begin @(negedge clk); n++; end
      if (n >= 20000) check("send_b_ready", rdy_b, 1);
      @(posedge clk);
      #1;
      t     = cyc;
      vld_b = 1'b0;
   endtask

   task automatic wait_frames_a(input int n);
      int t = 0;
      while (frames_a.size() < n && t < 20000) begin @(negedge clk); t++; end
      check("frames_a_count", frames_a.size(), n);
   endtask

   task automatic wait_frames_b(input int n);
      int t = 0;
      while (frames_b.size() < n && t < 20000) begin @(negedge clk); t++; end
      check("frames_b_count", frames_b.size(), n);
   endtask

   task automatic wait_bits_a(input int k);
      int t = 0;
      while (nbits_a != k && t < 2000) begin @(negedge clk); t++; end
      check("bits_a_reached", nbits_a, k);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got=running expected=finished");
      $fatal(1);
   end

   initial begin
      int          t, tv, bad;
      int          ta[4];
      logic [31:0] w;
      logic [31:0] exp_b[$];
      logic [31:0] wa[4];
      logic [55:0] f;

      rst_a = 1'b0; rst_b = 1'b0; tx_en_a = 1'b1; tx_en_b = 1'b1;
      vld_a = 1'b0; vld_b = 1'b0; din_a = '0; din_b = '0;
      repeat (3) @(negedge clk);
      check("rst_bit_out", bo_a, 0);
      check("rst_bit_valid", bv_a, 0);
      check("rst_frame_start", fs_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_ready_a", rdy_a, 1);
      check("rst_ready_b", rdy_b, 1);
      rst_a = 1'b1; rst_b = 1'b1;

      // BIT_DIV=1 single frame
      send_b(32'hDEADBEEF, t);
      wait_frames_b(1);
      check("t1_frame", frames_b[0], frame_of(8'h00, 32'hDEADBEEF));
      check("t1_latency", first_b[0] - t, 2);
      check("t1_busy_after_last", busy_last_b, 0);

      // BIT_DIV=1 back-to-back through the CNT wrap
      gap_chk_b = 1'b1;
      prev_b    = -1;
      for (int i = 1; i <= 256; i++) begin
         w = $urandom;
         exp_b.push_back(w);
         send_b(w, t);
      end
      wait_frames_b(257);
      gap_chk_b = 1'b0;
      bad = 0;
      for (int i = 1; i <= 256; i++)
         if (frames_b[i] !== frame_of(8'(i), exp_b[i-1])) bad++;
      check("b2b_frames_bad", bad, 0);
      f = frames_b[255];
      check("cnt_before_wrap", f[47:40], 8'hFF);
      f = frames_b[256];
      check("cnt_wrap", f[47:40], 8'h00);
      check("b2b_gap_bad", gap_bad_b, 0);

      // BIT_DIV=4 continuous input
      wa[0] = 32'h01234567; wa[1] = 32'h89ABCDEF; wa[2] = 32'h00000000; wa[3] = 32'hFFFFFFFF;
      gap_chk_a = 1'b1;
      prev_a    = -1;
      for (int i = 0; i < 4; i++) send_a(wa[i], ta[i]);
      wait_frames_a(4);
      gap_chk_a = 1'b0;
      for (int i = 0; i < 4; i++)
         check($sformatf("t3_frame%0d", i), frames_a[i], frame_of(8'(i), wa[i]));
      check("t3_latency", first_a[0] - ta[0], 5);
      check("t3_accept_1", ta[1] - ta[0], 2);
      check("t3_accept_steady", ta[3] - ta[2], 224);
      check("t3_gap_bad", gap_bad_a, 0);

      // tx_en dropped mid-frame with a word held
      send_a(32'hCAFEF00D, t);
      send_a(32'h12345678, t);
      wait_bits_a(20);
      tx_en_a = 1'b0;
      wait_frames_a(5);
      check("t4_frame_x", frames_a[4], frame_of(8'h04, 32'hCAFEF00D));
      repeat (300) @(negedge clk);
      check("t4_no_extra_frame", frames_a.size(), 5);
      check("t4_idle_busy", busy_a, 0);
      check("t4_held_ready", rdy_a, 0);
      tx_en_a = 1'b1;
      wait_frames_a(6);
      check("t4_frame_y", frames_a[5], frame_of(8'h05, 32'h12345678));

      // new word offered exactly on the last-bit edge with the hold register empty
      send_a(32'hA5A55A5A, t);
      wait_bits_a(55);
      repeat (2) @(negedge clk);
      send_a(32'h0F0FF0F0, tv);
      wait_frames_a(8);
      check("t6_frame_a", frames_a[6], frame_of(8'h06, 32'hA5A55A5A));
      check("t6_frame_b", frames_a[7], frame_of(8'h07, 32'h0F0FF0F0));
      check("t6_accept_edge", tv, last_a[6]);

      // asynchronous reset mid-frame with a word held
      send_a(32'h13579BDF, t);
      send_a(32'h2468ACE0, t);
      wait_bits_a(30);
      #1 rst_a = 1'b0;
      #1;
      check("t5_bit_out", bo_a, 0);
      check("t5_bit_valid", bv_a, 0);
      check("t5_frame_start", fs_a, 0);
      check("t5_busy", busy_a, 0);
      check("t5_ready", rdy_a, 1);
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      send_a(32'hFEDCBA98, t);
      wait_frames_a(9);
      check("t5_frame_after_rst", frames_a[8], frame_of(8'h00, 32'hFEDCBA98));
      repeat (300) @(negedge clk);
      check("t5_held_discarded", frames_a.size(), 9);

      check("frame_start_bad_a", fs_bad_a, 0);
      check("frame_start_bad_b", fs_bad_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
